nanov_sequencer: RTL
====================

NANOV_SEQUENCER -- requirements
Module: nanov_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded by reset.
REQ-002 SHALL have ports, in this order:
- clk  in  1  clock; one clock, all state on its rising edge.
- rstn  in  1  reset; synchronous, active-low.
- fetch_addr  out  32  address of the instruction requested.
- instr_in  in  32  fetched instruction word.
- instr_valid  in  1  instr_in valid.
- instr_ready  out  1  sequencer accepts instr_in this clock.
- instr  out  32  instruction presented to the core.
- cycle  out  3  current pass within the instruction.
- counter  out  5  current bit position, 0..31.
- pc  out  1  serial PC bit for the core's ALU.
- branch  in  1  core's taken-jump/branch strobe.
- data_out  in  32  core's stored-data register, holding the jump/branch target.
- retire  out  1  one-clock pulse on the last bit of the last pass.

Function
REQ-003 SHALL implement states FETCH and EXEC; a transfer occurs when instr_valid && instr_ready.
REQ-004 In FETCH, SHALL assert instr_ready, drive fetch_addr = pc_q, and hold counter = 0 and cycle = 0.
REQ-005 On a transfer in FETCH, SHALL latch instr_in into instr and enter EXEC on the next clock with counter = 0 and cycle = 0.
REQ-006 In EXEC, counter SHALL increment every clock, wrapping from 31 to 0; cycle SHALL increment on that wrap.
REQ-007 Pass count SHALL be:
- 2 for jumps (opcode[6:4]=110, opcode[2]=1);
- 2 for branches (opcode[6:2]=11000);
- 2 for shifts (opcode[4:2]=100, funct3[1:0]=01);
- 1 otherwise.
REQ-008 retire SHALL be 1 exactly when counter = 31 and cycle = pass count - 1.
REQ-009 pc SHALL equal pc_q[counter] combinationally.
REQ-010 SHALL set a taken flag when branch = 1 in any EXEC clock; the flag clears at retire.
REQ-011 At retire, SHALL update pc_q:
- if the taken flag is set or branch = 1: pc_q <= {data_out[31:1], 1'b0};
- else: pc_q <= pc_q + 4, 32-bit, wrapping 32'hFFFF_FFFC -> 0.
REQ-012 After retire without a buffered instruction, SHALL return to FETCH.
REQ-013 instr SHALL hold its value during EXEC; instr_in changes mid-instruction SHALL have no effect.
REQ-014 Outside FETCH (and outside the prefetch window of REQ-019), SHALL hold instr_ready = 0.

Reset
REQ-015 While rstn = 0 at a clock edge, SHALL set:
- state = FETCH; pc_q = RESET_PC;
- instr = 32'h0000_0013 (NOP); counter = 0; cycle = 0;
- retire = 0; taken flag clear; prefetch buffer empty.
REQ-016 Reset mid-EXEC SHALL abort the instruction with no PC update and no retire pulse.

Configuration
REQ-017 Macro NANOV_PREFETCH_EN SHALL compile in a one-entry prefetch buffer.
REQ-018 Without NANOV_PREFETCH_EN, SHALL have only FETCH/EXEC behaviour and exactly one bubble clock (FETCH) between instructions when instr_valid = 1.
REQ-019 With NANOV_PREFETCH_EN, in EXEC with an empty buffer:
- instr_ready = 1 and fetch_addr = pc_q + 4;
- a transfer fills the buffer.
REQ-020 With NANOV_PREFETCH_EN, at retire without a taken jump/branch and with the buffer full:
- SHALL load the buffer into instr, empty the buffer, and stay in EXEC with counter = 0, cycle = 0 (zero bubble).
REQ-021 With NANOV_PREFETCH_EN, at retire with a taken jump/branch:
- SHALL discard the buffer and go to FETCH;
- a transfer in that same clock SHALL also be discarded.

Structure
REQ-022 A shared package nanov_pkg SHALL hold:
- opcode constants (OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_OP, OPC_OP_IMM);
- NOP_INSTR = 32'h0000_0013;
- the state enum type.
REQ-023 Pass-count decode SHALL be a sub-module nanov_pass_decode (instr in, 2-bit pass count out); everything else inline.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, RESET_PC = 32'h100: after rstn rises -> fetch_addr = 32'h100, instr_ready = 1, instr = 32'h13.
- ADDI 32'h00500093 at pc 0 -> 32 EXEC clocks, retire at counter 31 cycle 0, then fetch_addr = 4.
- JAL, branch pulsed at cycle 0 counter 0, data_out = 32'h0000_0041 at retire -> 64 EXEC clocks, next fetch_addr = 32'h40.
- SLLI instruction -> cycle reaches 1, retire after 64 clocks, PC + 4.
- With NANOV_PREFETCH_EN, two ADDIs back-to-back with instr_valid held 1 -> second starts counter 0 on the clock after the first retires, no FETCH clock.
- With NANOV_PREFETCH_EN, taken BEQ (branch at counter 31 cycle 0) with buffer full -> buffer discarded, FETCH from the target; rstn low at counter 10 -> state FETCH, pc_q = RESET_PC.

Source files
------------

// File: rtl/nanov_pkg.sv
// Shared opcode constants, reset instruction and sequencer state type.
package nanov_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

endpackage

// File: rtl/nanov_pass_decode.sv
// Number of 32-clock serial passes an instruction needs: two for jumps,
// branches and shifts, one for everything else. Purely combinational.
module nanov_pass_decode
  import nanov_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  pass_cnt
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_jump;
  logic       is_branch;
  logic       is_shift;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // JAL and JALR share opcode[6:4] and opcode[2]; OP and OP-IMM share opcode[4:2].
  assign is_jump   = (opcode[6:4] == OPC_JALR[6:4]) && (opcode[2] == OPC_JAL[2]);
  assign is_branch = (opcode[6:2] == OPC_BRANCH[6:2]);
  assign is_shift  = (opcode[4:2] == OPC_OP[4:2]) && (funct3[1:0] == 2'b01);

  assign pass_cnt = (is_jump || is_branch || is_shift) ? 2'd2 : 2'd1;

  assign unused_bits = ^{instr[31:15], instr[11:7], instr[1:0]};

endmodule

// File: rtl/nanov_sequencer.sv
// Bit-serial instruction sequencer: fetches a word, then steps counter/cycle through its passes.
// Optional one-entry prefetch buffer enabled with `define NANOV_PREFETCH_EN.
module nanov_sequencer
  import nanov_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] fetch_addr,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] instr,
  output logic [2:0]  cycle,
  output logic [4:0]  counter,
  output logic        pc,
  input  logic        branch,
  input  logic [31:0] data_out,
  output logic        retire
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_d;
  logic [4:0]  counter_d;
  logic [2:0]  cycle_d;
  logic        taken_q, taken_d;
  logic [1:0]  pass_cnt;
  logic [2:0]  last_cycle;
  logic        xfer;
  logic        redirect;
  logic        unused_data;
`ifdef NANOV_PREFETCH_EN
  logic        buf_vld_q, buf_vld_d;
  logic [31:0] buf_q, buf_d;
`endif

  nanov_pass_decode u_pass_decode (
    .instr    (instr),
    .pass_cnt (pass_cnt)
  );

  assign last_cycle  = {1'b0, pass_cnt} - 3'd1;
  assign retire      = rstn && (state_q == EXEC) && (counter == 5'd31) && (cycle == last_cycle);
  assign pc          = pc_q[counter];
  assign xfer        = instr_valid && instr_ready;
  assign redirect    = taken_q || branch;
  assign unused_data = data_out[0];

`ifdef NANOV_PREFETCH_EN
  assign instr_ready = (state_q == FETCH) || !buf_vld_q;
  assign fetch_addr  = (state_q == EXEC) ? pc_q + 32'd4 : pc_q;
`else
  assign instr_ready = (state_q == FETCH);
  assign fetch_addr  = pc_q;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr;
    counter_d = counter;
    cycle_d   = cycle;
    taken_d   = taken_q;
`ifdef NANOV_PREFETCH_EN
    buf_vld_d = buf_vld_q;
    buf_d     = buf_q;
`endif
    case (state_q)
      FETCH: begin
        if (xfer) begin
          instr_d   = instr_in;
          state_d   = EXEC;
          counter_d = 5'd0;
          cycle_d   = 3'd0;
          taken_d   = 1'b0;
        end
      end
      EXEC: begin
        counter_d = counter + 5'd1;
        if (counter == 5'd31) cycle_d = cycle + 3'd1;
        if (branch) taken_d = 1'b1;
`ifdef NANOV_PREFETCH_EN
        if (xfer && !retire) begin
          buf_vld_d = 1'b1;
          buf_d     = instr_in;
        end
`endif
        if (retire) begin
          taken_d   = 1'b0;
          counter_d = 5'd0;
          cycle_d   = 3'd0;
          pc_d      = redirect ? {data_out[31:1], 1'b0} : pc_q + 32'd4;
          state_d   = FETCH;
`ifdef NANOV_PREFETCH_EN
          // A redirect invalidates anything fetched from the sequential path.
          if (redirect) begin
            buf_vld_d = 1'b0;
          end else if (buf_vld_q) begin
            instr_d   = buf_q;
            buf_vld_d = 1'b0;
            state_d   = EXEC;
          end else if (xfer) begin
            instr_d   = instr_in;
            state_d   = EXEC;
          end
`endif
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr     <= NOP_INSTR;
      counter   <= 5'd0;
      cycle     <= 3'd0;
      taken_q   <= 1'b0;
`ifdef NANOV_PREFETCH_EN
      buf_vld_q <= 1'b0;
      buf_q     <= NOP_INSTR;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr     <= instr_d;
      counter   <= counter_d;
      cycle     <= cycle_d;
      taken_q   <= taken_d;
`ifdef NANOV_PREFETCH_EN
      buf_vld_q <= buf_vld_d;
      buf_q     <= buf_d;
`endif
    end
  end

endmodule
